fifo_shell_param: RTL and testbench

- Parametrised successor to the 1-entry fifo_shell elastic stage; uses the same valid/ready handshake port naming.
- Circular-buffer FIFO of DEPTH entries, first-word-fall-through, with occupancy count, almost-full/almost-empty flags and synchronous flush.
- Sits between ISP pipeline stages (demosaic, colour correction, gamma) to absorb stalls and burstiness that a single-entry stage cannot.

---
 rtl/fifo_shell_param_if.sv | 29 ++
 rtl/fifo_shell_param.sv | 88 ++++++++
 tb/tb_fifo_shell_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_shell_param_if.sv
// Handshake bundle for fifo_shell_param: upstream push side, downstream pop side, flush and status.
// master = the environment driving the FIFO, slave = the FIFO itself.
interface fifo_shell_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                  u_i_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  i_i_ready;
    logic                  u_r_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  i_r_ready;
    logic                  flush;
    logic [CntW-1:0]       count;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output u_i_ready, data_in, u_r_ready, flush,
        input  i_i_ready, data_out, i_r_ready, count, almost_full, almost_empty
    );

    modport slave (
        input  u_i_ready, data_in, u_r_ready, flush,
        output i_i_ready, data_out, i_r_ready, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_shell_param.sv
// Circular-buffer FWFT FIFO with occupancy count, almost-full/empty flags and synchronous flush.
// Define FIFO_SHELL_BYPASS_EN for a zero-latency path through an empty FIFO.
module fifo_shell_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                clock,
    input  logic                reset,
    fifo_shell_param_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full  = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfLvl = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeLvl = CntW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == Full);

`ifdef FIFO_SHELL_BYPASS_EN
    assign w_bypass = w_empty & bus.u_i_ready & bus.u_r_ready & ~bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word is pushed and popped in the same cycle without touching storage.
    assign w_push = bus.u_i_ready & ~w_full & ~w_bypass;
    assign w_pop  = ~w_empty & bus.u_r_ready;

    assign bus.i_i_ready    = ~w_full;
    assign bus.i_r_ready    = ~w_empty | w_bypass;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= AfLvl);
    assign bus.almost_empty = (r_count <= AeLvl);

    always_comb begin
        bus.data_out = '0;
        if (w_bypass) begin
            bus.data_out = bus.data_in;
        end else if (!w_empty) begin
            bus.data_out = r_mem[r_rd_ptr];
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (reset && w_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_shell_param.sv
// Directed self-checking bench for fifo_shell_param (DATA_WIDTH=8, DEPTH=4, default flag levels).
// Expectations follow the FIFO_SHELL_BYPASS_EN setting of the build.
module tb_fifo_shell_param;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    fifo_shell_param_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

    fifo_shell_param #(
        .DATA_WIDTH(8),
        .DEPTH     (4),
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] exp_out [5];
        logic [2:0] exp_cnt [5];
        logic       exp_ir  [5];
        exp_out = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_cnt = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
        exp_ir  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        reset         = 1'b0;
        bus.u_i_ready = 1'b0;
        bus.data_in   = 8'h00;
        bus.u_r_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset state
        #12;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_i_r_ready", 32'(bus.i_r_ready), 32'd0);
        check("rst_i_i_ready", 32'(bus.i_i_ready), 32'd1);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_almost_full", 32'(bus.almost_full), 32'd0);
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        reset = 1'b1;

        // Single push, 1-cycle latency
        bus.u_i_ready = 1'b1;
        bus.data_in   = 8'hA5;
        #1;
        tick();
        bus.u_i_ready = 1'b0;
        #1;
        check("t1_i_r_ready", 32'(bus.i_r_ready), 32'd1);
        check("t1_data_out", 32'(bus.data_out), 32'hA5);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_almost_empty", 32'(bus.almost_empty), 32'd1);
        bus.u_r_ready = 1'b1;
        tick();
        bus.u_r_ready = 1'b0;
        #1;
        check("t1_drained", 32'(bus.count), 32'd0);

        // Fill past full with downstream stalled, then drain in order
        for (int v = 1; v <= 5; v++) begin
            bus.u_i_ready = 1'b1;
            bus.data_in   = 8'(v);
            #1;
            check("t2_fill_count", 32'(bus.count), 32'(v - 1));
            check("t2_fill_i_i_ready", 32'(bus.i_i_ready), 32'(v <= 4));
            check("t2_fill_almost_full", 32'(bus.almost_full), 32'(v - 1 >= 3));
            tick();
        end
        bus.u_r_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t2_drain_data", 32'(bus.data_out), 32'(exp_out[k]));
            check("t2_drain_i_r_ready", 32'(bus.i_r_ready), 32'd1);
            check("t2_drain_count", 32'(bus.count), 32'(exp_cnt[k]));
            check("t2_drain_i_i_ready", 32'(bus.i_i_ready), 32'(exp_ir[k]));
            check("t2_drain_almost_empty", 32'(bus.almost_empty), 32'(exp_cnt[k] <= 3'd1));
            tick();
            if (k == 1) bus.u_i_ready = 1'b0;
        end
        #1;
        check("t2_empty_count", 32'(bus.count), 32'd0);
        check("t2_empty_i_r_ready", 32'(bus.i_r_ready), 32'd0);

        // Streaming 0x00..0x0F with downstream always ready
        bus.u_r_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.u_i_ready = 1'b1;
            bus.data_in   = 8'(k);
            #1;
`ifdef FIFO_SHELL_BYPASS_EN
            check("t3_bypass_data", 32'(bus.data_out), 32'(k));
            check("t3_bypass_count", 32'(bus.count), 32'd0);
`else
            if (k > 0) begin
                check("t3_stream_data", 32'(bus.data_out), 32'(k - 1));
                check("t3_stream_count", 32'(bus.count), 32'd1);
            end else begin
                check("t3_first_i_r_ready", 32'(bus.i_r_ready), 32'd0);
            end
`endif
            tick();
        end
        bus.u_i_ready = 1'b0;
        #1;
`ifndef FIFO_SHELL_BYPASS_EN
        check("t3_last_data", 32'(bus.data_out), 32'h0F);
        check("t3_last_count", 32'(bus.count), 32'd1);
`endif
        tick();
        bus.u_r_ready = 1'b0;
        #1;
        check("t3_end_count", 32'(bus.count), 32'd0);

        // Flush at count=3 with a concurrent push
        for (int k = 0; k < 3; k++) begin
            bus.u_i_ready = 1'b1;
            bus.data_in   = 8'(8'h10 + k);
            tick();
        end
        bus.flush   = 1'b1;
        bus.data_in = 8'h77;
        #1;
        check("t4_pre_count", 32'(bus.count), 32'd3);
        check("t4_pre_almost_full", 32'(bus.almost_full), 32'd1);
        tick();
        bus.flush     = 1'b0;
        bus.u_i_ready = 1'b0;
        #1;
        check("t4_count", 32'(bus.count), 32'd0);
        check("t4_i_r_ready", 32'(bus.i_r_ready), 32'd0);
        check("t4_data_out", 32'(bus.data_out), 32'h00);
        check("t4_almost_empty", 32'(bus.almost_empty), 32'd1);
        bus.u_i_ready = 1'b1;
        bus.data_in   = 8'h55;
        tick();
        bus.u_i_ready = 1'b0;
        #1;
        check("t4_after_data", 32'(bus.data_out), 32'h55);
        check("t4_after_count", 32'(bus.count), 32'd1);
        bus.u_r_ready = 1'b1;
        tick();
        bus.u_r_ready = 1'b0;
        #1;
        check("t4_after_empty", 32'(bus.count), 32'd0);

        // Asynchronous reset mid-cycle at count=2
        bus.u_i_ready = 1'b1;
        bus.data_in   = 8'h21;
        tick();
        bus.data_in   = 8'h22;
        tick();
        bus.u_i_ready = 1'b0;
        #1;
        check("t5_pre_count", 32'(bus.count), 32'd2);
        reset = 1'b0;
        #1;
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_i_r_ready", 32'(bus.i_r_ready), 32'd0);
        check("t5_i_i_ready", 32'(bus.i_i_ready), 32'd1);
        check("t5_data_out", 32'(bus.data_out), 32'h00);
        check("t5_almost_empty", 32'(bus.almost_empty), 32'd1);
        check("t5_almost_full", 32'(bus.almost_full), 32'd0);
        reset = 1'b1;
        tick();
        #1;
        check("t5_post_count", 32'(bus.count), 32'd0);

        // Empty FIFO, downstream ready, single push of 0x3C
        bus.u_r_ready = 1'b1;
        bus.u_i_ready = 1'b1;
        bus.data_in   = 8'h3C;
        #1;
`ifdef FIFO_SHELL_BYPASS_EN
        check("t6_bypass_i_r_ready", 32'(bus.i_r_ready), 32'd1);
        check("t6_bypass_data", 32'(bus.data_out), 32'h3C);
        check("t6_bypass_count", 32'(bus.count), 32'd0);
        check("t6_bypass_i_i_ready", 32'(bus.i_i_ready), 32'd1);
        tick();
        bus.u_i_ready = 1'b0;
        #1;
        check("t6_bypass_after_count", 32'(bus.count), 32'd0);
        check("t6_bypass_after_i_r_ready", 32'(bus.i_r_ready), 32'd0);
`else
        check("t6_no_bypass_i_r_ready", 32'(bus.i_r_ready), 32'd0);
        check("t6_no_bypass_data", 32'(bus.data_out), 32'h00);
        tick();
        bus.u_i_ready = 1'b0;
        #1;
        check("t6_latency_i_r_ready", 32'(bus.i_r_ready), 32'd1);
        check("t6_latency_data", 32'(bus.data_out), 32'h3C);
        check("t6_latency_count", 32'(bus.count), 32'd1);
        tick();
        #1;
        check("t6_drained_count", 32'(bus.count), 32'd0);
`endif
        bus.u_r_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
